// File: rtl/bfc_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : bfc_pkg
//  Purpose  : Shared types and constants for the bound-flasher checker.
//             Holds the phase enumeration, the LED count bounds and a
//             helper that converts a count into a thermometer code.
//  Revision : 1.0 - initial release
// ============================================================================
package bfc_pkg;

    typedef enum logic [2:0] {
        PH_IDLE = 3'd0,
        PH_P1   = 3'd1,
        PH_P2   = 3'd2,
        PH_P3   = 3'd3,
        PH_P4   = 3'd4,
        PH_P5   = 3'd5,
        PH_P6   = 3'd6
    } phase_e;

    localparam int unsigned N_W    = 5;
    localparam int unsigned LED_W  = 16;

    localparam logic [N_W-1:0] c_p1_top = 5'd6;
    localparam logic [N_W-1:0] c_p3_top = 5'd11;
    localparam logic [N_W-1:0] c_p4_bot = 5'd5;
    localparam logic [N_W-1:0] c_p5_top = 5'd16;
    localparam logic [N_W-1:0] c_bottom = 5'd0;

    // Lowest n bits set; n is never above 16.
    function automatic logic [LED_W-1:0] thermo(input logic [N_W-1:0] n);
        logic [LED_W-1:0] t;
        for (int i = 0; i < LED_W; i++) begin
            t[i] = (N_W'(i) < n);
        end
        return t;
    endfunction

endpackage : bfc_pkg
`default_nettype wire

// File: rtl/bfc_ref_model.sv
`default_nettype none
// ============================================================================
//  Module   : bfc_ref_model
//  Purpose  : Reference model of the bound flasher. Tracks the phase and the
//             lit-LED count n, and presents the registered expected LED
//             vector plus a busy flag.
//  Ports    : clk      - clock, all state on posedge
//             rst_n    - asynchronous active-low reset
//             flick    - flick input, sampled on posedge
//             exp_led  - registered thermometer code of n
//             busy     - registered (phase != IDLE)
//  Revision : 1.0 - initial release
// ============================================================================
module bfc_ref_model
    import bfc_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flick,
    output logic [LED_W-1:0] exp_led,
    output logic             busy
);

    phase_e           phase_q, phase_d;
    logic [N_W-1:0]   n_q, n_d;
    logic [LED_W-1:0] exp_led_q, exp_led_d;
    logic             busy_q, busy_d;

    logic [N_W-1:0]   w_n_inc;
    logic [N_W-1:0]   w_n_dec;

    assign w_n_inc = n_q + 5'd1;
    assign w_n_dec = n_q - 5'd1;

    // Phase changes on the same edge that n reaches the bound, so the
    // kickback decision samples flick on that edge.
    always_comb begin
        phase_d = phase_q;
        n_d     = n_q;
        unique case (phase_q)
            PH_IDLE: begin
                if (flick) begin
                    phase_d = PH_P1;
                    n_d     = 5'd1;
                end else begin
                    n_d     = c_bottom;
                end
            end
            PH_P1: begin
                n_d = w_n_inc;
                if (w_n_inc == c_p1_top) phase_d = PH_P2;
            end
            PH_P2: begin
                n_d = w_n_dec;
                if (w_n_dec == c_bottom) phase_d = flick ? PH_P1 : PH_P3;
            end
            PH_P3: begin
                n_d = w_n_inc;
                if (w_n_inc == c_p3_top) phase_d = PH_P4;
            end
            PH_P4: begin
                n_d = w_n_dec;
                if (w_n_dec == c_p4_bot) phase_d = flick ? PH_P3 : PH_P5;
            end
            PH_P5: begin
                n_d = w_n_inc;
                if (w_n_inc == c_p5_top) phase_d = PH_P6;
            end
            PH_P6: begin
                n_d = w_n_dec;
                if (w_n_dec == c_bottom) phase_d = PH_IDLE;
            end
            default: begin
                phase_d = PH_IDLE;
                n_d     = c_bottom;
            end
        endcase
        exp_led_d = thermo(n_d);
        busy_d    = (phase_d != PH_IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phase_q   <= PH_IDLE;
            n_q       <= c_bottom;
            exp_led_q <= '0;
            busy_q    <= 1'b0;
        end else begin
            phase_q   <= phase_d;
            n_q       <= n_d;
            exp_led_q <= exp_led_d;
            busy_q    <= busy_d;
        end
    end

    assign exp_led = exp_led_q;
    assign busy    = busy_q;

endmodule : bfc_ref_model
`default_nettype wire

// File: rtl/bound_flasher_checker.sv
`default_nettype none
// ============================================================================
//  Module   : bound_flasher_checker
//  Purpose  : Checks a bound-flasher LED bus against a reference model and
//             counts mismatching cycles.
//  Ports    : clk      - clock, all state on posedge
//             rst_n    - asynchronous active-low reset
//             flick    - same flick the checked flasher receives
//             led      - LED bus under check
//             exp_led  - expected LED vector from the reference model
//             busy     - model not idle
//             err      - mismatch flag, one cycle after the mismatch
//             err_cnt  - saturating count of mismatching cycles
//  Config   : BFC_STICKY_ERR_EN - when defined, err latches at the first
//             mismatch and holds until reset; err_cnt is unaffected.
//  Revision : 1.0 - initial release
// ============================================================================
module bound_flasher_checker
    import bfc_pkg::*;
#(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flick,
    input  logic [15:0]      led,
    output logic [15:0]      exp_led,
    output logic             busy,
    output logic             err,
    output logic [CNT_W-1:0] err_cnt
);

    logic [LED_W-1:0] w_exp_led;
    logic             w_busy;
    logic             w_mismatch;

    logic             armed_q, armed_d;
    logic             err_q, err_d;
    logic [CNT_W-1:0] err_cnt_q, err_cnt_d;

    bfc_ref_model u_ref_model (
        .clk     (clk),
        .rst_n   (rst_n),
        .flick   (flick),
        .exp_led (w_exp_led),
        .busy    (w_busy)
    );

    // The first edge after reset release only arms the compare: the
    // checked flasher may still be leaving its own reset on that edge.
    assign w_mismatch = armed_q && (led != w_exp_led);

    always_comb begin
        armed_d   = 1'b1;
`ifdef BFC_STICKY_ERR_EN
        err_d     = err_q | w_mismatch;
`else
        err_d     = w_mismatch;
`endif
        err_cnt_d = err_cnt_q;
        if (w_mismatch && (err_cnt_q != {CNT_W{1'b1}})) begin
            err_cnt_d = err_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            armed_q   <= 1'b0;
            err_q     <= 1'b0;
            err_cnt_q <= '0;
        end else begin
            armed_q   <= armed_d;
            err_q     <= err_d;
            err_cnt_q <= err_cnt_d;
        end
    end

    assign exp_led = w_exp_led;
    assign busy    = w_busy;
    assign err     = err_q;
    assign err_cnt = err_cnt_q;

endmodule : bound_flasher_checker
`default_nettype wire

// File: tb/tb_bound_flasher_checker.sv
`default_nettype none
// ============================================================================
//  Module   : tb_bound_flasher_checker
//  Purpose  : Self-checking bench for bound_flasher_checker: directed
//             scenarios followed by randomized flick/LED stimulus, all
//             checked against a behavioural model of the flasher rules.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_bound_flasher_checker;

    logic        clk;
    logic        rst_n;
    logic        flick;
    logic [15:0] led;
    logic [15:0] exp_led;
    logic        busy;
    logic        err;
    logic [7:0]  err_cnt;

    int n_total;
    int n_pass;
    int n_fail;

    // Behavioural model: stage -1 is idle, stages 0..5 walk toward the
    // bound held in targets[]; direction follows from target versus n.
    int targets [6] = '{6, 0, 11, 5, 16, 0};
    int m_stage;
    int m_n;
    bit m_armed;
    bit m_err;
    int m_cnt;

    bound_flasher_checker #(.CNT_W(8)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .flick   (flick),
        .led     (led),
        .exp_led (exp_led),
        .busy    (busy),
        .err     (err),
        .err_cnt (err_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [15:0] lamp(input int n);
        logic [31:0] v;
        v = (32'd1 << n) - 32'd1;
        return v[15:0];
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_total++;
        assert (obs === expv) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".exp_led"}, {16'h0, exp_led}, {16'h0, lamp(m_n)});
        chk({tag, ".busy"},    {31'h0, busy},    {31'h0, (m_stage >= 0)});
        chk({tag, ".err"},     {31'h0, err},     {31'h0, m_err});
        chk({tag, ".err_cnt"}, {24'h0, err_cnt}, m_cnt);
    endtask

    task automatic model_reset();
        m_stage = -1;
        m_n     = 0;
        m_armed = 1'b0;
        m_err   = 1'b0;
        m_cnt   = 0;
    endtask

    task automatic model_edge(input bit f, input logic [15:0] l);
        bit mm;
        mm = m_armed && (l != lamp(m_n));
        m_armed = 1'b1;
`ifdef BFC_STICKY_ERR_EN
        m_err = m_err | mm;
`else
        m_err = mm;
`endif
        if (mm && m_cnt != 255) m_cnt++;
        if (m_stage < 0) begin
            if (f) begin
                m_stage = 0;
                m_n     = 1;
            end
        end else begin
            m_n += (targets[m_stage] > m_n) ? 1 : -1;
            if (m_n == targets[m_stage]) begin
                case (m_stage)
                    1:       m_stage = f ? 0 : 2;
                    3:       m_stage = f ? 2 : 4;
                    5:       m_stage = -1;
                    default: m_stage = m_stage + 1;
                endcase
            end
        end
    endtask

    task automatic cycle(input bit f, input logic [15:0] l, input string tag);
        flick = f;
        led   = l;
        @(posedge clk);
        model_edge(f, l);
        #1;
        check_all(tag);
    endtask

    // Holds rst_n low across two edges with flick high, then releases
    // between edges.
    task automatic do_reset();
        #1;
        rst_n = 1'b0;
        model_reset();
        #1;
        check_all("reset_async");
        flick = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check_all("reset_held");
        rst_n = 1'b1;
        flick = 1'b0;
    endtask

    task automatic run_to(input int s, input int n, input int bound, input string tag);
        int i;
        i = 0;
        while (i < bound && !(m_stage == s && m_n == n)) begin
            cycle(1'b0, lamp(m_n), tag);
            i++;
        end
        chk({tag, ".reached"}, {31'h0, (m_stage == s && m_n == n)}, 32'd1);
    endtask

    initial begin
        int base;
        int steps;
        n_total = 0;
        n_pass  = 0;
        n_fail  = 0;
        rst_n   = 1'b1;
        flick   = 1'b0;
        led     = 16'h0;
        model_reset();
        @(posedge clk);

        // Reset state, then a single flick with no kickbacks.
        do_reset();
        chk("rst.exp_led", {16'h0, exp_led}, 32'h0);
        chk("rst.err_cnt", {24'h0, err_cnt}, 32'h0);
        cycle(1'b0, lamp(m_n), "idle");
        cycle(1'b1, lamp(m_n), "start");
        chk("start.first", {16'h0, exp_led}, 32'h0001);
        steps = 0;
        while (m_stage >= 0 && steps < 100) begin
            cycle(1'b0, lamp(m_n), "seq");
            steps++;
        end
        chk("seq.done_idle", {31'h0, busy}, 32'h0);
        chk("seq.no_err",    {24'h0, err_cnt}, 32'h0);

        // Kickback at the bottom of P2 restarts P1.
        cycle(1'b1, lamp(m_n), "start2");
        run_to(1, 1, 50, "to_p2");
        cycle(1'b1, lamp(m_n), "kick_p2");
        cycle(1'b0, lamp(m_n), "after_kick_p2");
        chk("kick_p2.restart", {16'h0, exp_led}, 32'h0001);

        // Kickback at the bottom of P4 resumes P3.
        run_to(3, 6, 100, "to_p4");
        cycle(1'b1, lamp(m_n), "kick_p4");
        cycle(1'b0, lamp(m_n), "after_kick_p4");
        chk("kick_p4.resume", {16'h0, exp_led}, 32'h003F);

        // No kickback at the bottom of P6.
        run_to(5, 1, 200, "to_p6");
        cycle(1'b1, lamp(m_n), "p6_end");
        chk("p6_end.exp_led", {16'h0, exp_led}, 32'h0);
        chk("p6_end.busy",    {31'h0, busy},    32'h0);
        cycle(1'b0, lamp(m_n), "p6_idle");

        // Two forced mismatches.
        cycle(1'b1, lamp(m_n), "start3");
        run_to(0, 3, 10, "to_n3");
        base = m_cnt;
        cycle(1'b0, 16'h0003, "force1");
        chk("force1.err", {31'h0, err}, 32'h1);
        cycle(1'b0, 16'h0003, "force2");
        chk("force2.err", {31'h0, err}, 32'h1);
        chk("force2.err_cnt", {24'h0, err_cnt}, base + 2);
        cycle(1'b0, lamp(m_n), "force_end");

        // Reset in the middle of P3.
        run_to(2, 4, 100, "to_p3");
        do_reset();
        chk("midrst.exp_led", {16'h0, exp_led}, 32'h0);
        chk("midrst.err_cnt", {24'h0, err_cnt}, 32'h0);
        repeat (4) cycle(1'b0, lamp(m_n), "midrst_idle");
        cycle(1'b1, lamp(m_n), "midrst_start");
        chk("midrst.restart", {16'h0, exp_led}, 32'h0001);

        // Randomized flick and occasional LED corruption.
        for (int i = 0; i < 1500; i++) begin
            logic [15:0] l;
            l = lamp(m_n);
            if ($urandom_range(15) == 0) l = 16'($urandom);
            cycle(($urandom_range(7) == 0), l, "rand");
        end

        // Drive the counter into saturation.
        for (int i = 0; i < 300; i++) begin
            cycle(($urandom_range(3) == 0), ~lamp(m_n), "sat");
        end
        chk("sat.err_cnt", {24'h0, err_cnt}, 32'hFF);

        do_reset();
        cycle(1'b0, 16'hFFFF, "post_rst_suppressed");
        chk("post_rst.err", {31'h0, err}, 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule : tb_bound_flasher_checker
`default_nettype wire
